mem_bus_arbiter: RTL and testbench

- Shares the single-ported main memory between two requesters: the CPU instruction-fetch port and the CPU data (load/store) port.
- Sequences each memory access: accept, drive the address, wait a fixed read latency, return the data.
- Sits between the cpu core and the memory; it owns mem_addr and the memory control signals.
- One transaction in flight at a time; fixed-priority or round-robin selection.

---
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the cpu core ports, the main memory and mem_bus_arbiter.
//   fetch port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   memory     : mem_addr, mem_en, mem_we, mem_wdata -> mem_data
// Modport slave is the arbiter's view; modport master is the core/memory view.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 28
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [31:0]       mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_en, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_en, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the single-ported main memory between the cpu fetch and data ports.
// One access in flight: accept in IDLE, drive memory for MEM_LATENCY cycles in
// WAIT, return data with a one-cycle rvalid in RESP. All outputs registered.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - mem_bus_arbiter_if.slave (requester handshakes + memory bus)
//   busy - high whenever the FSM is not in IDLE
// Optional macro ARB_ROUND_ROBIN_EN: on a tie, grant the port that did not win
// last time (last-grant resets to fetch). Undefined: data beats fetch.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_bus_arbiter_if.slave       bus,
  output logic                   busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;   // 1 = data port owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              pick;               // winner of the current arbitration
  logic              accept;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;     // 1 = data won the previous grant
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  // Arbitration between the two requesters
  always_comb begin
    pick = bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.d_req && bus.if_req) begin
      pick = ~last_q;
    end
`endif
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
          owner_d = pick;
          we_d    = pick & bus.d_we;
          addr_d  = pick ? bus.d_addr : bus.if_addr;
          wdata_d = pick ? bus.d_wdata : 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick;
`endif
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          state_d = RESP;
          cnt_d   = '0;
          if (owner_q) begin
            d_rdata_d = we_q ? 32'd0 : bus.mem_data;
          end else begin
            if_rdata_d = bus.mem_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs describe the state being entered, so they flop alongside it
    accept      = (state_q == IDLE) && (state_d == WAIT);
    if_gnt_d    = accept & ~owner_d;
    d_gnt_d     = accept & owner_d;
    if_rvalid_d = (state_d == RESP) & ~owner_d;
    d_rvalid_d  = (state_d == RESP) & owner_d;
    mem_en_d    = (state_d == WAIT);
    mem_we_d    = (state_d == WAIT) & we_d;
    busy_d      = (state_d != IDLE);
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = 32'(addr_q);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Instance u_dut uses MEM_LATENCY=2,
// u_dut1 uses MEM_LATENCY=1. Cycle c is the clock period after edge c, where
// edge 0 is the accepting edge; outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 28;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic busy1;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(2)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}
  function automatic logic [6:0] st();
    return {bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
            bus.mem_en, bus.mem_we, busy};
  endfunction

  function automatic logic [6:0] st1();
    return {bus1.if_gnt, bus1.if_rvalid, bus1.d_gnt, bus1.d_rvalid,
            bus1.mem_en, bus1.mem_we, busy1};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req   = 1'b0; bus.if_addr  = '0;
    bus.d_req    = 1'b0; bus.d_we     = 1'b0;
    bus.d_addr   = '0;   bus.d_wdata  = '0;
    bus.mem_data = '0;
    bus1.if_req  = 1'b0; bus1.if_addr = '0;
    bus1.d_req   = 1'b0; bus1.d_we    = 1'b0;
    bus1.d_addr  = '0;   bus1.d_wdata = '0;
    bus1.mem_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if ({st(), bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%b addr=%h wd=%h ird=%h drd=%h required all 0",
               st(), bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({st(), st1(), bus1.mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got st=%b st1=%b addr1=%h required 0", st(), st1(), bus1.mem_addr);
    end
    next_cycle();
  endtask

  task automatic test_fetch();
    logic [6:0] exp;
    bus.if_addr  = 28'h0000010;
    bus.mem_data = 32'hDEADBEEF;
    bus.if_req   = 1'b1;
    next_cycle();
    bus.if_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp = {c == 1, c == 3, 1'b0, 1'b0, c <= 2, 1'b0, c <= 3};
      checks++;
      if (st() !== exp) begin
        errors++;
        $display("FAIL fetch_status c%0d: got %b required %b", c, st(), exp);
      end
      if (c <= 2) begin
        checks++;
        if (bus.mem_addr !== 32'h00000010) begin
          errors++;
          $display("FAIL fetch_addr c%0d: got %h required 00000010", c, bus.mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (bus.if_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL fetch_rdata: got %h required deadbeef", bus.if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [6:0] exp [7];
    exp = '{7'b0010101, 7'b0000101, 7'b0001001, 7'b0000000,
            7'b1000101, 7'b0000101, 7'b0100001};
    bus.d_addr   = 28'h0000020;
    bus.d_we     = 1'b0;
    bus.if_addr  = 28'h0000030;
    bus.mem_data = 32'h11111111;
    bus.d_req    = 1'b1;
    bus.if_req   = 1'b1;
    next_cycle();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (st() !== exp[c-1]) begin
        errors++;
        $display("FAIL priority_status c%0d: got %b required %b", c, st(), exp[c-1]);
      end
      if (c == 1) begin
        checks++;
        if (bus.mem_addr !== 32'h00000020) begin
          errors++;
          $display("FAIL priority_daddr: got %h required 00000020", bus.mem_addr);
        end
        bus.d_req = 1'b0;
      end
      if (c == 3) begin
        checks++;
        if (bus.d_rdata !== 32'h11111111) begin
          errors++;
          $display("FAIL priority_drdata: got %h required 11111111", bus.d_rdata);
        end
      end
      if (c == 4) bus.mem_data = 32'h22222222;
      if (c == 5) begin
        checks++;
        if (bus.mem_addr !== 32'h00000030) begin
          errors++;
          $display("FAIL priority_iaddr: got %h required 00000030", bus.mem_addr);
        end
        bus.if_req = 1'b0;
      end
      if (c == 7) begin
        checks++;
        if ({bus.if_rdata, bus.d_rdata} !== {32'h22222222, 32'h11111111}) begin
          errors++;
          $display("FAIL priority_rdata_hold: got if=%h d=%h required 22222222 11111111",
                   bus.if_rdata, bus.d_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_store();
    logic [6:0] exp [4];
    exp = '{7'b0010111, 7'b0000111, 7'b0001001, 7'b0000000};
    bus.d_addr   = 28'h0000020;
    bus.d_we     = 1'b1;
    bus.d_wdata  = 32'h12345678;
    bus.mem_data = 32'hCAFEF00D;
    bus.d_req    = 1'b1;
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (st() !== exp[c-1]) begin
        errors++;
        $display("FAIL store_status c%0d: got %b required %b", c, st(), exp[c-1]);
      end
      if (c <= 2) begin
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {32'h00000020, 32'h12345678}) begin
          errors++;
          $display("FAIL store_bus c%0d: got addr=%h wd=%h required 00000020 12345678",
                   c, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (c == 1) bus.d_req = 1'b0;
      if (c == 3) begin
        checks++;
        if ({bus.d_rdata, bus.if_rdata} !== {32'h00000000, 32'h22222222}) begin
          errors++;
          $display("FAIL store_rdata: got d=%h if=%h required 00000000 22222222",
                   bus.d_rdata, bus.if_rdata);
        end
      end
      next_cycle();
    end
    bus.d_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.if_addr  = 28'h0000044;
    bus.mem_data = 32'h55555555;
    bus.if_req   = 1'b1;
    @(posedge clk);
    #3;
    bus.if_req = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({st(), bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got st=%b addr=%h wd=%h ird=%h drd=%h required all 0",
               st(), bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (st() !== 7'b0) begin
        errors++;
        $display("FAIL midreset_quiet c%0d: got %b required 0000000", c, st());
      end
    end
    next_cycle();
    test_fetch();
  endtask

  task automatic test_both_held();
    logic [1:0] exp;
    logic [1:0] got;
    int         k;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    bus.d_addr   = 28'h0000060;
    bus.d_we     = 1'b0;
    bus.if_addr  = 28'h0000070;
    bus.mem_data = 32'h00000077;
    bus.d_req    = 1'b1;
    bus.if_req   = 1'b1;
    next_cycle();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      got = {bus.d_gnt, bus.if_gnt};
      exp = 2'b00;
      if ((c - 1) % 4 == 0) begin
        k = (c - 1) / 4;
`ifdef ARB_ROUND_ROBIN_EN
        exp = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
        exp = 2'b10;
`endif
        checks++;
        if (bus.mem_addr !== (exp[1] ? 32'h00000060 : 32'h00000070)) begin
          errors++;
          $display("FAIL held_addr grant%0d: got %h required %h", k, bus.mem_addr,
                   exp[1] ? 32'h00000060 : 32'h00000070);
        end
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held_grant c%0d: got {d,if}=%b required %b", c, got, exp);
      end
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_latency1();
    logic [6:0] exp [3];
    exp = '{7'b1000101, 7'b0100001, 7'b0000000};
    bus1.if_addr  = 28'hFFFFFFF;
    bus1.mem_data = 32'hA5A5A5A5;
    bus1.if_req   = 1'b1;
    next_cycle();
    bus1.if_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (st1() !== exp[c-1]) begin
        errors++;
        $display("FAIL lat1_status c%0d: got %b required %b", c, st1(), exp[c-1]);
      end
      if (c == 1) begin
        checks++;
        if (bus1.mem_addr !== 32'h0FFFFFFF) begin
          errors++;
          $display("FAIL lat1_addr: got %h required 0fffffff", bus1.mem_addr);
        end
      end
      if (c == 2) begin
        checks++;
        if (bus1.if_rdata !== 32'hA5A5A5A5) begin
          errors++;
          $display("FAIL lat1_rdata: got %h required a5a5a5a5", bus1.if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_reset_mid();
    test_both_held();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
